div_seq_ctrl: RTL and testbench

- Sequencer that computes signed 32-bit division (quotient to LO, remainder to HI) for the DIV instruction, one restoring step per cycle.
- All arithmetic is done on the shared 64-bit add/sub unit. This block drives that unit's x, y and c_in and samples its combinational sum in the same cycle.
- Sits beside the ALU. The control unit starts it and waits for done before latching HI/LO.

---
 rtl/div_seq_pkg.sv | 42 ++++
 rtl/div_add_opmux.sv | 45 ++++
 rtl/div_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// ============================================================================
//  Module   : div_seq_pkg
//  Purpose  : Shared types and constants for the sequential signed divider.
//             Holds the FSM state encoding and the add/sub operand-select codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

   // Width of the shared add/sub unit; fixed regardless of operand width
   localparam int ADD_W = 64;

   // Restoring steps per division; equals the default operand width
   localparam int ITER_COUNT = 32;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ABS_N = 3'd1,
      ST_ABS_D = 3'd2,
      ST_ITER  = 3'd3,
      ST_FIX_Q = 3'd4,
      ST_FIX_R = 3'd5,
      ST_DONE  = 3'd6
   } div_state_e;

   // Adder operand encodings
   //   OP_ZERO : x=0,  y=0,   cin=0  (adder idle)
   //   OP_PASS : x=v,  y=0,   cin=0  (pass-through)
   //   OP_NEG  : x=~v, y=0,   cin=1  (two's-complement negate)
   //   OP_SUB  : x=v,  y=~w,  cin=1  (v - w)
   typedef enum logic [1:0] {
      OP_ZERO = 2'd0,
      OP_PASS = 2'd1,
      OP_NEG  = 2'd2,
      OP_SUB  = 2'd3
   } add_op_e;

endpackage

`default_nettype wire

// File: rtl/div_add_opmux.sv
// ============================================================================
//  Module   : div_add_opmux
//  Purpose  : Combinational select of the shared adder's x, y and carry-in
//             from an operation code and pre-extended 64-bit operands.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_add_opmux
   import div_seq_pkg::*;
(
   input  add_op_e          op,
   input  logic [ADD_W-1:0] opnd_x,
   input  logic [ADD_W-1:0] opnd_y,
   output logic [ADD_W-1:0] add_x,
   output logic [ADD_W-1:0] add_y,
   output logic             add_cin
);

   // Map the operation code onto adder inputs; idle drives all zeros
   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      case (op)
         OP_PASS: begin
            add_x = opnd_x;
         end
         OP_NEG: begin
            add_x   = ~opnd_x;
            add_cin = 1'b1;
         end
         OP_SUB: begin
            add_x   = opnd_x;
            add_y   = ~opnd_y;
            add_cin = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
// ============================================================================
//  Module   : div_seq_ctrl
//  Purpose  : Sequencer for signed WIDTH-bit division (quotient -> lo,
//             remainder -> hi), one restoring step per cycle, using an
//             external shared 64-bit add/sub unit for all arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_ctrl
   import div_seq_pkg::*;
#(
   parameter int WIDTH = ITER_COUNT,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic [ADD_W-1:0] add_x,
   output logic [ADD_W-1:0] add_y,
   output logic             add_cin,
   input  logic [ADD_W-1:0] add_s
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Sign-extend a WIDTH-bit value to the adder width
   function automatic logic [ADD_W-1:0] sext_w(input logic [WIDTH-1:0] v);
      return {{(ADD_W-WIDTH){v[WIDTH-1]}}, v};
   endfunction

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] dvd_q,   dvd_d;
   logic [WIDTH-1:0] dvs_q,   dvs_d;
   logic [WIDTH:0]   a_q,     a_d;
   logic [WIDTH-1:0] q_q,     q_d;
   logic [WIDTH-1:0] m_q,     m_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             sq_q,    sq_d;
   logic             sr_q,    sr_d;
   logic [WIDTH-1:0] lo_q,    lo_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic             dz_q,    dz_d;

   add_op_e          op_sel;
   logic [ADD_W-1:0] opnd_x;
   logic [ADD_W-1:0] opnd_y;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH-1:0] q_shift;
   logic             unused_sink;

   // {A,Q} shifted left by one; A' never exceeds 2*M-1 so bit WIDTH stays 0
   assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign q_shift = {q_q[WIDTH-2:0], 1'b0};

   // Only the low result bits and the sign bit of the sum are consumed
   assign unused_sink = ^{add_s, a_q};

   // Choose adder operation and operands for the current compute state
   always_comb begin
      op_sel = OP_ZERO;
      opnd_x = '0;
      opnd_y = '0;
      case (state_q)
         ST_ABS_N: begin
            opnd_x = sext_w(dvd_q);
            op_sel = dvd_q[WIDTH-1] ? OP_NEG : OP_PASS;
         end
         ST_ABS_D: begin
            opnd_x = sext_w(dvs_q);
            op_sel = dvs_q[WIDTH-1] ? OP_NEG : OP_PASS;
         end
         ST_ITER: begin
            opnd_x = {{(ADD_W-WIDTH-1){a_shift[WIDTH]}}, a_shift};
            opnd_y = {{(ADD_W-WIDTH){1'b0}}, m_q};
            op_sel = OP_SUB;
         end
         ST_FIX_Q: begin
            opnd_x = sext_w(q_q);
            op_sel = sq_q ? OP_NEG : OP_PASS;
         end
         ST_FIX_R: begin
            opnd_x = sext_w(a_q[WIDTH-1:0]);
            op_sel = sr_q ? OP_NEG : OP_PASS;
         end
         default: begin
         end
      endcase
   end

   div_add_opmux u_opmux (
      .op      (op_sel),
      .opnd_x  (opnd_x),
      .opnd_y  (opnd_y),
      .add_x   (add_x),
      .add_y   (add_y),
      .add_cin (add_cin)
   );

   // Next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dz_d    = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dvd_d = dividend;
               dvs_d = divisor;
               dz_d  = 1'b0;
               sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sr_d  = dividend[WIDTH-1];
               if (divisor == '0) begin
                  lo_d    = '1;
                  hi_d    = dividend;
                  dz_d    = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ABS_N;
               end
            end
         end
         ST_ABS_N: begin
            // |dividend| goes straight into Q, ready for the first shift
            q_d     = add_s[WIDTH-1:0];
            state_d = ST_ABS_D;
         end
         ST_ABS_D: begin
            m_d     = add_s[WIDTH-1:0];
            a_d     = '0;
            cnt_d   = '0;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            if (add_s[ADD_W-1]) begin
               a_d = a_shift;
               q_d = q_shift;
            end else begin
               a_d = add_s[WIDTH:0];
               q_d = q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX_Q;
            end
         end
         ST_FIX_Q: begin
            lo_d    = add_s[WIDTH-1:0];
            state_d = ST_FIX_R;
         end
         ST_FIX_R: begin
            hi_d    = add_s[WIDTH-1:0];
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dz_q    <= dz_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign div_zero = dz_q;
   assign lo       = lo_q;
   assign hi       = hi_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
// ============================================================================
//  Module   : tb_div_seq_ctrl
//  Purpose  : Directed self-checking bench for div_seq_ctrl with a behavioural
//             64-bit adder attached to the add_* ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_seq_ctrl;

   logic        clk      = 1'b0;
   logic        clr      = 1'b1;
   logic        start    = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor  = '0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] lo;
   logic [31:0] hi;
   logic [63:0] add_x;
   logic [63:0] add_y;
   logic        add_cin;
   logic [63:0] add_s;

   int n_checks = 0;
   int n_fail   = 0;

   // Shared adder model
   assign add_s = add_x + add_y + {63'd0, add_cin};

   always #5 clk = ~clk;

   div_seq_ctrl #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .lo       (lo),
      .hi       (hi),
      .add_x    (add_x),
      .add_y    (add_y),
      .add_cin  (add_cin),
      .add_s    (add_s)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called just after the accepting edge; counts edges until done is seen
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edz, input int elat);
      int lat;
      int bc;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, bc);
      chk({tag, "_lat"},  64'(lat), 64'(elat));
      chk({tag, "_busy"}, 64'(bc),  64'(elat));
      chk({tag, "_lo"},   64'(lo),  64'(elo));
      chk({tag, "_hi"},   64'(hi),  64'(ehi));
      chk({tag, "_dz"},   64'(div_zero), 64'(edz));
      @(posedge clk); #1;
      chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin
      int lat;
      int bc;
      logic seen_done;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy),     64'd0);
      chk("rst_done", 64'(done),     64'd0);
      chk("rst_dz",   64'(div_zero), 64'd0);
      chk("rst_lo",   64'(lo),       64'd0);
      chk("rst_hi",   64'(hi),       64'd0);
      chk("rst_addx", add_x,         64'd0);
      chk("rst_addy", add_y,         64'd0);
      chk("rst_cin",  64'(add_cin),  64'd0);
      @(negedge clk);
      clr = 1'b0;

      run_div("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36);

      // -100 / 7 with a look at the negate operands in ABS_N
      @(negedge clk);
      start    = 1'b1;
      dividend = 32'hFFFF_FF9C;
      divisor  = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      chk("absn_x",   add_x,        64'd99);
      chk("absn_y",   add_y,        64'd0);
      chk("absn_cin", 64'(add_cin), 64'd1);
      wait_done(lat, bc);
      chk("n100_p7_lat", 64'(lat), 64'd36);
      chk("n100_p7_lo",  64'(lo),  64'hFFFF_FFF2);
      chk("n100_p7_hi",  64'(hi),  64'hFFFF_FFFE);
      @(posedge clk); #1;
      chk("idle_addx", add_x,        64'd0);
      chk("idle_cin",  64'(add_cin), 64'd0);

      run_div("p100_n7",   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 36);
      run_div("ovf",       32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 36);
      run_div("min_by_1",  32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 36);
      run_div("max_by_min",32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b0, 36);
      run_div("n7_p2",     32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 36);
      run_div("dz55",      32'd55,        32'd0,         32'hFFFF_FFFF, 32'd55,        1'b1, 0);
      run_div("p9_p3",     32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 36);

      // start held high; operands changed mid-operation must not be used
      @(negedge clk);
      start    = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(posedge clk); #1;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (lat == 10) begin
            dividend = 32'd50;
            divisor  = 32'd5;
         end
         @(posedge clk); #1;
         lat++;
      end
      chk("held_lat", 64'(lat), 64'd36);
      chk("held_lo",  64'(lo),  64'd14);
      chk("held_hi",  64'(hi),  64'd2);
      dividend = 32'd9;
      divisor  = 32'd4;
      @(posedge clk); #1;
      chk("held_gap_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("held_reaccept", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done(lat, bc);
      chk("held2_lat", 64'(lat), 64'd36);
      chk("held2_lo",  64'(lo),  64'd2);
      chk("held2_hi",  64'(hi),  64'd1);
      @(posedge clk); #1;

      // Asynchronous clear in the middle of ITER
      @(negedge clk);
      start    = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      chk("clr_pre_busy", 64'(busy), 64'd1);
      #2 clr = 1'b1;
      #1;
      chk("clr_busy", 64'(busy),     64'd0);
      chk("clr_done", 64'(done),     64'd0);
      chk("clr_lo",   64'(lo),       64'd0);
      chk("clr_hi",   64'(hi),       64'd0);
      chk("clr_addx", add_x,         64'd0);
      chk("clr_cin",  64'(add_cin),  64'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      @(negedge clk);
      clr = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      chk("clr_no_done", 64'(seen_done), 64'd0);

      run_div("p20_p6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 36);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
